// File: rtl/dram_pkg.sv
// dram_pkg: shared widths, latency counter width and read FSM encoding for the data-memory controller.
package dram_pkg;
    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W = 4;
    typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_e;
endpackage

// File: rtl/dram_array.sv
// dram_array: DEPTH x DATA_W word storage, synchronous write, asynchronous read, never reset.
module dram_array
    import dram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/dram_ctrl.sv
// dram_ctrl: fixed-latency data-memory controller with a single-entry posted-write buffer,
// read-after-write forwarding and a valid/ready request handshake.
module dram_ctrl
    import dram_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = 4096,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid
);
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    state_e            state_q, state_d;
    logic              wb_valid_q;
    logic [ADDR_W-1:0] wb_addr_q, rd_addr_q;
    logic [DATA_W-1:0] wb_data_q, fwd_data_q, rdata_q, arr_rdata, rd_data;
    logic [CNT_W-1:0]  wb_cnt_q, rd_cnt_q;
    logic              fwd_q, rdata_valid_q;
    logic              acc, wr_acc, rd_acc, commit, rd_done;

    assign acc     = req_valid && req_ready;
    assign wr_acc  = acc && req_we;
    assign rd_acc  = acc && !req_we;
    assign commit  = wb_valid_q && wb_cnt_q == '0;
    assign rd_done = state_q == RD_WAIT && rd_cnt_q == '0;
    // A write draining on the same edge as the response must be visible to it.
    assign rd_data = fwd_q ? fwd_data_q :
                     (commit && wb_addr_q == rd_addr_q) ? wb_data_q : arr_rdata;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == IDLE ? (rd_acc ? RD_WAIT : IDLE) : (rd_done ? IDLE : RD_WAIT);
    end

    always_comb begin
        req_ready = state_q == IDLE && (!req_we || !wb_valid_q || wb_cnt_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q    <= 1'b0;
            wb_cnt_q      <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            rdata_valid_q <= rd_done;
            if (rd_done) rdata_q <= rd_data;
            if (wr_acc) begin
                wb_valid_q <= 1'b1;
                wb_cnt_q   <= LAT_M1;
            end else begin
                if (commit) wb_valid_q <= 1'b0;
                if (wb_cnt_q != '0) wb_cnt_q <= wb_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            wb_addr_q <= req_addr;
            wb_data_q <= req_wdata;
        end
        if (rd_acc) begin
            rd_addr_q  <= req_addr;
            rd_cnt_q   <= LAT_M1;
            fwd_q      <= wb_valid_q && wb_addr_q == req_addr;
            fwd_data_q <= wb_data_q;
        end else if (state_q == RD_WAIT && rd_cnt_q != '0) begin
            rd_cnt_q <= rd_cnt_q - 1'b1;
        end
    end

    dram_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
        .clk     (clk),
        .we_i    (commit && !rst),
        .waddr_i (wb_addr_q),
        .wdata_i (wb_data_q),
        .raddr_i (rd_addr_q),
        .rdata_o (arr_rdata)
    );

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
endmodule

// File: tb/tb_dram_ctrl.sv
// tb_dram_ctrl: directed vector table, reset corner cases and randomized traffic checked
// against a transaction-level memory model with acceptance and response timing rules.
module tb_dram_ctrl;
    localparam int LAT = 2;

    logic        clk = 1'b0, rst = 1'b1, req_valid = 1'b0, req_we = 1'b0;
    logic [11:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready, rdata_valid;
    logic [31:0] rdata;

    dram_ctrl #(.ADDR_W(12), .DATA_W(32), .DEPTH(4096), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rdata(rdata), .rdata_valid(rdata_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {logic [31:0] data; int due;} rsp_t;
    typedef struct {bit we; logic [11:0] addr; logic [31:0] data; int gap; int delay; logic [31:0] exp_rd;} vec_t;

    rsp_t        q[$];
    int          checks = 0, errors = 0;
    logic [31:0] ref_mem [int];
    bit          pend_v = 0;
    logic [11:0] pend_a;
    logic [31:0] pend_d;
    int          pend_e, last_rd = -1000, last_wr = -1000;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [11:0] a);
        return (pend_v && pend_a == a) ? pend_d : ref_mem[int'(a)];
    endfunction

    // Presents one request; exp_delay < 0 or use_model selects the model's prediction.
    task automatic issue(input bit we, input logic [11:0] a, input logic [31:0] d, input int gap,
                         input int exp_delay, input bit use_model, input logic [31:0] exp_rd);
        int first, earliest, n;
        repeat (gap + 1) @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        #1;
        first = cyc + 1;
        earliest = first;
        if (last_rd + LAT + 1 > earliest) earliest = last_rd + LAT + 1;
        if (we && last_wr + LAT > earliest) earliest = last_wr + LAT;
        n = 0;
        while (!req_ready && n < 40) begin
            @(negedge clk); #1; n++;
        end
        if (!req_ready) begin
            errors++; checks++;
            $display("FAIL accept_timeout: got no ready after %0d cycles expected ready", n);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk(we ? "wr_accept_delay" : "rd_accept_delay", n, exp_delay < 0 ? earliest - first : exp_delay);
        if (we) begin
            if (pend_v) ref_mem[int'(pend_a)] = pend_d;
            pend_v = 1; pend_a = a; pend_d = d; pend_e = cyc + LAT; last_wr = cyc;
        end else begin
            last_rd = cyc;
            q.push_back('{use_model ? model_rd(a) : exp_rd, cyc + LAT});
        end
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        q.delete();
        if (pend_v && pend_e < cyc) ref_mem[int'(pend_a)] = pend_d;
        pend_v = 0; last_rd = -1000; last_wr = -1000;
        @(negedge clk) rst = 1'b0;
        #1;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_rdata_valid", {31'b0, rdata_valid}, 32'h0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rdata_valid) begin
                if (q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL unexpected_pulse: got rdata_valid=1 rdata=%h expected no pulse", rdata);
                end else begin
                    chk("rsp_data", rdata, q[0].data);
                    chk("rsp_cycle", cyc, q[0].due);
                    void'(q.pop_front());
                end
            end else if (q.size() > 0) begin
                if (cyc > q[0].due) begin
                    errors++; checks++;
                    $display("FAIL missing_pulse: got no rdata_valid at cycle %0d expected at %0d", cyc, q[0].due);
                    void'(q.pop_front());
                end else begin
                    chk("ready_in_rd_wait", {31'b0, req_ready}, 32'h0);
                end
            end
        end
    end

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{1, 12'h005, 32'h0000004B, 0, 0, 32'h0};
        vecs[1]  = '{0, 12'h005, 32'h0,        3, 0, 32'h0000004B};
        vecs[2]  = '{1, 12'h001, 32'h0000000C, 3, 0, 32'h0};
        vecs[3]  = '{0, 12'h001, 32'h0,        0, 0, 32'h0000000C};
        vecs[4]  = '{0, 12'h001, 32'h0,        0, 2, 32'h0000000C};
        vecs[5]  = '{1, 12'h002, 32'h00000014, 3, 0, 32'h0};
        vecs[6]  = '{1, 12'h003, 32'h00000019, 0, 1, 32'h0};
        vecs[7]  = '{0, 12'h002, 32'h0,        3, 0, 32'h00000014};
        vecs[8]  = '{0, 12'h003, 32'h0,        3, 0, 32'h00000019};
        vecs[9]  = '{1, 12'h011, 32'h00000045, 3, 0, 32'h0};
        vecs[10] = '{1, 12'h010, 32'h0000004B, 3, 0, 32'h0};
        vecs[11] = '{0, 12'h011, 32'h0,        0, 0, 32'h00000045};
        vecs[12] = '{0, 12'h010, 32'h0,        3, 0, 32'h0000004B};
        vecs[13] = '{1, 12'h004, 32'h00000045, 3, 0, 32'h0};

        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1;
        chk("init_rdata", rdata, 32'h0);
        chk("init_rdata_valid", {31'b0, rdata_valid}, 32'h0);
        chk("init_ready", {31'b0, req_ready}, 32'h1);

        foreach (vecs[i]) issue(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].gap, vecs[i].delay, 0, vecs[i].exp_rd);

        issue(1, 12'h004, 32'hFFFFFFFF, 3, 0, 0, 32'h0);
        do_reset();
        issue(0, 12'h004, 32'h0, 0, 0, 0, 32'h00000045);

        issue(0, 12'h005, 32'h0, 3, 0, 0, 32'h0000004B);
        do_reset();
        repeat (4) begin
            @(negedge clk); #1;
            chk("abort_no_pulse", {31'b0, rdata_valid}, 32'h0);
        end

        for (int a = 0; a < 16; a++) issue(1, 12'(a), $urandom, 0, -1, 1, 32'h0);
        for (int i = 0; i < 400; i++)
            issue(1'($urandom % 2), 12'($urandom % 16), $urandom, int'($urandom % 3), -1, 1, 32'h0);

        repeat (LAT + 4) @(negedge clk);
        if (q.size() != 0) begin
            errors++; checks++;
            $display("FAIL drain: got %0d outstanding responses expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dram_ctrl.md
Name: dram_ctrl

Overview:
- Data-memory controller directly downstream of the single-core processor.
- Consumes the processor's address register, write-enable and data register outputs; returns read data on the processor's Data input.
- Owns a synchronous word-addressed array, a single-entry posted-write buffer and a read FSM with fixed access latency.
- Exposes a valid/ready request handshake so the core can stall.

Parameters:
- ADDR_W, 12, address width; matches the processor's AR width.
- DATA_W, 32, data word width; matches the processor's DR width.
- DEPTH, 4096, number of words; must equal 2**ADDR_W.
- LATENCY, 2, cycles from request acceptance to read response or array write; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  processor presents a request.
- req_ready  out  1  controller accepts the request this cycle.
- req_we  in  1  1 = write, 0 = read; the processor's write-enable.
- req_addr  in  ADDR_W  word address; the processor's AR output.
- req_wdata  in  DATA_W  write data; the processor's DR output.
- rdata  out  DATA_W  read response data; drives the processor's Data input.
- rdata_valid  out  1  one-cycle pulse qualifying rdata.

Behaviour:
- Handshake: a request is accepted on a rising edge where req_valid && req_ready. Requester holds all req_* stable until accepted.
- Reset values: rdata=0, rdata_valid=0, FSM=IDLE, wb_valid=0, wb_cnt=0. The array is not reset. rst overrides all other activity on that edge.
- Write buffer state: wb_valid, wb_addr, wb_data, wb_cnt.
  - Write accept loads the buffer with wb_valid=1 and wb_cnt=LATENCY-1.
  - wb_cnt decrements each cycle while nonzero.
  - On an edge where wb_valid && wb_cnt==0: mem[wb_addr] <= wb_data and wb_valid clears, unless a new write is accepted on the same edge, in which case it reloads.
  - Net effect: a write accepted at edge T updates the array at edge T+LATENCY.
- req_ready = (fsm==IDLE) && (!req_we || !wb_valid || wb_cnt==0). This is combinational from req_we.
- FSM states: IDLE and RD_WAIT.
  - IDLE, read accepted: latch rd_addr; load rd_cnt=LATENCY-1; go to RD_WAIT.
  - Forwarding: if at accept wb_valid && wb_addr==req_addr, set fwd=1 and capture wb_data; otherwise fwd=0.
  - RD_WAIT: req_ready=0. Decrement rd_cnt.
  - RD_WAIT with rd_cnt==0 at the edge: rdata <= fwd ? captured data : mem[rd_addr], where the array read sees any write that commits on that same edge. Then rdata_valid <= 1 and FSM returns to IDLE.
  - Read accepted at edge T gives rdata_valid high during the cycle after edge T+LATENCY for exactly 1 cycle. rdata holds its value until the next response.
- LATENCY=1: RD_WAIT is entered with rd_cnt=0 and lasts exactly one cycle.
- Writes accepted in IDLE do not change FSM state. A write may be accepted in the same cycle a read response pulses.
- Address range: addresses are always in range because DEPTH=2**ADDR_W. There is no wrap logic.
- Reset mid-operation:
  - A pending buffered write is dropped and the array is unchanged.
  - An in-flight read is aborted with no rdata_valid pulse.
- Simultaneous drain and new write (wb_cnt==0): the old entry commits and the new entry loads on the same edge.

Decomposition:
- Shared package dram_pkg:
  - ADDR_W and DATA_W defaults.
  - FSM state encoding: IDLE=1'b0, RD_WAIT=1'b1.
  - Latency counter width constant (4 bits).
- One sub-module, dram_array: single-port-write / async-read storage, DEPTH x DATA_W, with write enable, write address/data and read address.
- Controller FSM, write buffer and forwarding logic live in dram_ctrl.

Test Plan (all with LATENCY=2):
- Reset, array preloaded with mem[0x005]=0x0000004B; read 0x005 accepted at edge T -> rdata_valid pulse one cycle after edge T+2; rdata=0x0000004B; req_ready=0 during RD_WAIT.
- Write 0x0000000C to 0x001 at edge T, then read 0x001 at edge T+1 (forward path) -> rdata=0x0000000C. A later read of 0x001 also returns 0x0000000C.
- Write 0x14 to 0x002 at edge T; write 0x19 to 0x003 presented at T+1 -> req_ready=0 for that cycle, accepted at edge T+2. mem[0x002]=0x14 after T+2; mem[0x003]=0x19 after T+4.
- Read request held during RD_WAIT of a prior read -> not accepted until the FSM returns to IDLE. Two distinct responses, no lost or duplicated rdata_valid pulses.
- mem[0x004]=0x45; write 0xFFFFFFFF to 0x004 at edge T; rst high at edge T+1 -> subsequent read of 0x004 returns 0x00000045. rdata and rdata_valid are 0 after reset.
- Write 0x4B to 0x010 pending; read 0x011 (mem=0x45) accepted next edge -> rdata=0x45, no forwarding. mem[0x010]=0x4B after drain.
